ball_motion_ctrl: RTL and testbench
===================================

// Module: ball_motion_ctrl
// PURPOSE
//  Pong ball engine; sits directly downstream of the clock divider.
//  - Consumes the divider's slow, registered square wave; each rising edge advances the ball one step.
//  - Closes the loop: drives the divider's 4-bit speed select, raising speed as paddle hits accumulate.
//  - Outputs ball position to the VGA renderer and one-cycle score pulses to the scoreboard.
// PARAMETERS
//  X_MAX     159  rightmost ball column; X range 0..X_MAX, 8-bit
//  Y_MAX     119  bottom ball row; Y range 0..Y_MAX, 7-bit
//  X_START    80  serve column
//  Y_START    60  serve row
//  PAD_LX      4  left paddle face column
//  PAD_RX    155  right paddle face column
//  PAD_H      16  paddle height in rows
//  HITS_PER_LVL 4  paddle hits per speed-level increment
// PORTS
//  Clk       in   1  100 MHz system clock, same domain as the divider
//  Rst       in   1  asynchronous, active-high reset
//  StepClk   in   1  divider output; rising edge = one motion step
//  Serve     in   1  debounced serve request, level-sensitive
//  PadLY     in   7  left paddle top row
//  PadRY     in   7  right paddle top row
//  BallX     out  8  ball column
//  BallY     out  7  ball row
//  Active    out  1  1 while in PLAY
//  ScoreL    out  1  1-cycle pulse: left player scored (ball left via right edge)
//  ScoreR    out  1  1-cycle pulse: right player scored (ball left via left edge)
//  SpeedSel  out  4  to divider select input; 0=slowest .. 3=fastest; bits[3:2] always 0
// BEHAVIOUR
//  Reset: BallX=X_START, BallY=Y_START, Active=0, ScoreL=ScoreR=0, SpeedSel=0; HitCnt=0; dx=+1, dy=+1; ServeDir=right; FSM=IDLE; StepPrev=0.
//  Step detect: StepPrev<=StepClk every Clk; Step = StepClk & ~StepPrev.
//   - No synchronizer: StepClk is already a Clk-domain register output.
//  FSM states: IDLE, PLAY, SCORED.
//  IDLE
//   - Ball held at (X_START, Y_START); Steps ignored.
//   - Serve=1 -> PLAY next cycle; dx=ServeDir, dy=+1; HitCnt=0; SpeedSel=0; ServeDir toggles.
//  PLAY
//   - Active=1; Serve ignored.
//   - On Step only, registered on the same Clk edge, so new position is visible 1 Clk after Step:
//   - Vertical: if (Y==0 && dy<0) or (Y==Y_MAX && dy>0), flip dy and move the reflected way; else Y+=dy.
//   - Left paddle: dx<0 && X==PAD_LX+1 && PadLY<=Y<=PadLY+PAD_H-1 -> dx=+1, X+=1, hit.
//   - Right paddle: mirror with PAD_RX-1 and PadRY.
//   - Paddle range compare is done at 8 bits, so PadLY+PAD_H carries instead of wrapping.
//   - Paddle check uses pre-step Y. Corner case: wall and paddle on the same Step flip both dx and dy.
//   - Miss left: X==0 && dx<0 -> ScoreR=1, enter SCORED; X is not decremented, so no wrap.
//   - Miss right: X==X_MAX && dx>0 -> ScoreL=1, enter SCORED.
//   - Each hit: HitCnt+=1. When HitCnt reaches HITS_PER_LVL, clear it; SpeedSel+=1, saturating at 3.
//  SCORED
//   - Score pulse is high exactly 1 Clk (the SCORED cycle).
//   - Ball is recentred, SpeedSel=0, Active=0, then IDLE next cycle.
//   - A Serve held high through SCORED is seen in IDLE and re-serves.
//  Async reset mid-PLAY: all state returns to reset values immediately; no score pulse.
// STRUCTURE
//  - pong_pkg: FSM state encoding (IDLE/PLAY/SCORED), screen and paddle constants, width localparams (XW=8, YW=7).
//  - Sub-module step_edge_det (Clk, Rst, In, Rise): rising-edge pulse generator; reused by the serve-button path.
//  - Remaining logic stays flat: FSM, position/direction registers, hit counter, speed register.
// TESTING
//  1. Reset: assert Rst mid-PLAY at (100,30) -> same-cycle (80,60), SpeedSel=0, Active=0; no Score pulse.
//  2. Serve from reset, 3 Steps -> ball (83,63); Active=1; SpeedSel=0; a Serve pulse while in PLAY has no effect.
//  3. Wall bounce: Y=1, dy=-1, 2 Steps -> Y=0 then Y=1; dy=+1.
//  4. Paddle hit: X=5, dx=-1, Y=40, PadLY=30, Step -> X=6, dx=+1. Repeat with PadLY=41: X=4, no hit.
//  5. Speed ramp: 4 hits -> SpeedSel=1; 16 hits -> 3; 20 hits -> still 3.
//  6. Miss: X=0, dx=-1, Step -> ScoreR high exactly 1 Clk; ball (80,60), IDLE, SpeedSel=0; next serve goes the opposite way.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared screen geometry, paddle constants and FSM encoding for the pong ball engine.
package pong_pkg;

  localparam int XW = 8;
  localparam int YW = 7;

  localparam logic [XW-1:0] X_MAX   = 8'd159;
  localparam logic [XW-1:0] X_START = 8'd80;
  localparam logic [XW-1:0] PAD_LX  = 8'd4;
  localparam logic [XW-1:0] PAD_RX  = 8'd155;
  localparam logic [XW-1:0] PAD_H   = 8'd16;

  localparam logic [YW-1:0] Y_MAX   = 7'd119;
  localparam logic [YW-1:0] Y_START = 7'd60;

  localparam int HITS_PER_LVL = 4;
  localparam int HCW          = $clog2(HITS_PER_LVL);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    SCORED = 2'd2
  } state_t;

  // Widened to 8 bits so top+PAD_H near the bottom row carries rather than wrapping.
  function automatic logic in_paddle(input logic [YW-1:0] y, input logic [YW-1:0] top);
    logic [XW-1:0] y8;
    logic [XW-1:0] t8;
    y8 = {1'b0, y};
    t8 = {1'b0, top};
    return (y8 >= t8) && (y8 <= t8 + PAD_H - 8'd1);
  endfunction

endpackage

// File: rtl/step_edge_det.sv
// Rising-edge pulse generator for a signal already registered in the Clk domain.
// Rise is combinational and lasts one Clk cycle; no synchronizer stage.
module step_edge_det (
  input  logic Clk,
  input  logic Rst,
  input  logic In,
  output logic Rise
);

  logic prev;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) prev <= 1'b0;
    else     prev <= In;
  end

  assign Rise = In & ~prev;

endmodule

// File: rtl/ball_motion_ctrl.sv
// Pong ball engine: one motion step per StepClk rise, paddle/wall reflection, scoring, speed ramp.
// New position visible 1 Clk after the step edge; score pulses last exactly one Clk.
module ball_motion_ctrl
  import pong_pkg::*;
(
  input  logic          Clk,
  input  logic          Rst,
  input  logic          StepClk,
  input  logic          Serve,
  input  logic [YW-1:0] PadLY,
  input  logic [YW-1:0] PadRY,
  output logic [XW-1:0] BallX,
  output logic [YW-1:0] BallY,
  output logic          Active,
  output logic          ScoreL,
  output logic          ScoreR,
  output logic [3:0]    SpeedSel
);

  state_t         state, state_nxt;
  logic           step;
  logic [XW-1:0]  x, x_nxt;
  logic [YW-1:0]  y, y_nxt;
  logic           dx_neg, dx_neg_nxt;
  logic           dy_neg, dy_neg_nxt;
  logic           serve_left;
  logic           miss_left;
  logic [HCW-1:0] hit_cnt;
  logic [1:0]     speed;
  logic           hit, miss_l, miss_r;

  step_edge_det u_step_edge (
    .Clk  (Clk),
    .Rst  (Rst),
    .In   (StepClk),
    .Rise (step)
  );

  // Candidate next position from the pre-step coordinates.
  always_comb begin
    y_nxt      = y;
    dy_neg_nxt = dy_neg;
    x_nxt      = x;
    dx_neg_nxt = dx_neg;
    hit        = 1'b0;
    miss_l     = 1'b0;
    miss_r     = 1'b0;

    if (dy_neg && y == '0) begin
      dy_neg_nxt = 1'b0;
      y_nxt      = 7'd1;
    end else if (!dy_neg && y == Y_MAX) begin
      dy_neg_nxt = 1'b1;
      y_nxt      = Y_MAX - 7'd1;
    end else begin
      y_nxt = dy_neg ? y - 7'd1 : y + 7'd1;
    end

    if (dx_neg && x == '0) begin
      miss_l = 1'b1;
    end else if (!dx_neg && x == X_MAX) begin
      miss_r = 1'b1;
    end else if (dx_neg && x == PAD_LX + 8'd1 && in_paddle(y, PadLY)) begin
      dx_neg_nxt = 1'b0;
      x_nxt      = x + 8'd1;
      hit        = 1'b1;
    end else if (!dx_neg && x == PAD_RX - 8'd1 && in_paddle(y, PadRY)) begin
      dx_neg_nxt = 1'b1;
      x_nxt      = x - 8'd1;
      hit        = 1'b1;
    end else begin
      x_nxt = dx_neg ? x - 8'd1 : x + 8'd1;
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Serve) state_nxt = PLAY;
      PLAY:    if (step && (miss_l || miss_r)) state_nxt = SCORED;
      SCORED:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    Active = (state == PLAY);
    ScoreR = (state == SCORED) &&  miss_left;
    ScoreL = (state == SCORED) && !miss_left;
  end

  // The ball is recentred on the same edge that enters SCORED, so the pulse cycle already shows the serve spot.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      x          <= X_START;
      y          <= Y_START;
      dx_neg     <= 1'b0;
      dy_neg     <= 1'b0;
      serve_left <= 1'b0;
      miss_left  <= 1'b0;
      hit_cnt    <= '0;
      speed      <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          x <= X_START;
          y <= Y_START;
          if (Serve) begin
            dx_neg     <= serve_left;
            dy_neg     <= 1'b0;
            hit_cnt    <= '0;
            speed      <= 2'd0;
            serve_left <= ~serve_left;
          end
        end
        PLAY: begin
          if (step) begin
            if (miss_l || miss_r) begin
              x         <= X_START;
              y         <= Y_START;
              speed     <= 2'd0;
              hit_cnt   <= '0;
              miss_left <= miss_l;
            end else begin
              x      <= x_nxt;
              y      <= y_nxt;
              dx_neg <= dx_neg_nxt;
              dy_neg <= dy_neg_nxt;
              if (hit) begin
                if (hit_cnt == HCW'(HITS_PER_LVL - 1)) begin
                  hit_cnt <= '0;
                  if (speed != 2'd3) speed <= speed + 2'd1;
                end else begin
                  hit_cnt <= hit_cnt + HCW'(1);
                end
              end
            end
          end
        end
        default: begin
          x <= X_START;
          y <= Y_START;
        end
      endcase
    end
  end

  assign BallX    = x;
  assign BallY    = y;
  assign SpeedSel = {2'b00, speed};

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// Directed bench for ball_motion_ctrl: serve, walls, paddles, speed ramp, misses, async reset.
module tb_ball_motion_ctrl;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       StepClk;
  logic       Serve;
  logic [6:0] PadLY, PadRY;
  logic [7:0] BallX;
  logic [6:0] BallY;
  logic       Active, ScoreL, ScoreR;
  logic [3:0] SpeedSel;

  int errors = 0;
  int checks = 0;
  int n = 0;

  always #5 Clk = ~Clk;

  ball_motion_ctrl dut (
    .Clk(Clk), .Rst(Rst), .StepClk(StepClk), .Serve(Serve),
    .PadLY(PadLY), .PadRY(PadRY),
    .BallX(BallX), .BallY(BallY), .Active(Active),
    .ScoreL(ScoreL), .ScoreR(ScoreR), .SpeedSel(SpeedSel)
  );

  // Row after k steps from a serve at row 60 moving down: triangle wave of period 238.
  function automatic logic [6:0] ref_y(input int k);
    int u;
    u = (60 + k) % 238;
    return 7'((u <= 119) ? u : 238 - u);
  endfunction

  task automatic do_step;
    @(negedge Clk); StepClk = 1'b1;
    @(negedge Clk); StepClk = 1'b0;
    n++;
  endtask

  task automatic step_to(input int target);
    while (n < target) do_step();
  endtask

  task automatic step_track(input int target);
    while (n < target) begin
      PadLY = BallY;
      PadRY = BallY;
      do_step();
    end
  endtask

  task automatic serve;
    @(negedge Clk); Serve = 1'b1;
    @(negedge Clk); Serve = 1'b0;
    n = 0;
  endtask

  task automatic test_reset;
    Rst = 1'b1; StepClk = 1'b0; Serve = 1'b0; PadLY = 7'd0; PadRY = 7'd0;
    #12;
    checks++; if (BallX !== 8'd80) begin errors++; $display("FAIL rst_x: got %0d want 80", BallX); end
    checks++; if (BallY !== 7'd60) begin errors++; $display("FAIL rst_y: got %0d want 60", BallY); end
    checks++; if ({Active, ScoreL, ScoreR} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b want 000", {Active, ScoreL, ScoreR}); end
    checks++; if (SpeedSel !== 4'd0) begin errors++; $display("FAIL rst_speed: got %0d want 0", SpeedSel); end
    @(negedge Clk); Rst = 1'b0;
    do_step();
    checks++; if (BallX !== 8'd80 || BallY !== 7'd60 || Active !== 1'b0) begin
      errors++; $display("FAIL idle_ignores_step: got (%0d,%0d) act=%b want (80,60) act=0", BallX, BallY, Active); end
  endtask

  task automatic test_serve;
    PadLY = 7'd30; PadRY = 7'd100;
    serve();
    checks++; if (Active !== 1'b1) begin errors++; $display("FAIL serve_active: got %b want 1", Active); end
    step_to(3);
    checks++; if (BallX !== 8'd83 || BallY !== 7'd63) begin errors++; $display("FAIL serve_3steps: got (%0d,%0d) want (83,63)", BallX, BallY); end
    checks++; if (SpeedSel !== 4'd0) begin errors++; $display("FAIL serve_speed: got %0d want 0", SpeedSel); end
    @(negedge Clk); Serve = 1'b1;
    @(negedge Clk); Serve = 1'b0;
    @(negedge Clk);
    checks++; if (BallX !== 8'd83 || BallY !== 7'd63 || Active !== 1'b1) begin
      errors++; $display("FAIL serve_in_play: got (%0d,%0d) act=%b want (83,63) act=1", BallX, BallY, Active); end
  endtask

  task automatic test_paddle_right;
    step_to(74);
    checks++; if (BallX !== 8'd154 || BallY !== ref_y(74)) begin errors++; $display("FAIL pre_rhit: got (%0d,%0d) want (154,%0d)", BallX, BallY, ref_y(74)); end
    do_step();
    checks++; if (BallX !== 8'd153 || BallY !== ref_y(75)) begin errors++; $display("FAIL rhit: got (%0d,%0d) want (153,%0d)", BallX, BallY, ref_y(75)); end
  endtask

  task automatic test_wall_bounce;
    step_to(177);
    checks++; if (BallX !== 8'd51 || BallY !== 7'd1) begin errors++; $display("FAIL wall_pre: got (%0d,%0d) want (51,1)", BallX, BallY); end
    do_step();
    checks++; if (BallY !== 7'd0) begin errors++; $display("FAIL wall_y0: got %0d want 0", BallY); end
    do_step();
    checks++; if (BallY !== 7'd1) begin errors++; $display("FAIL wall_y1: got %0d want 1", BallY); end
    do_step();
    checks++; if (BallY !== 7'd2) begin errors++; $display("FAIL wall_dy_pos: got %0d want 2", BallY); end
  endtask

  task automatic test_paddle_left;
    step_to(223);
    checks++; if (BallX !== 8'd5 || BallY !== 7'd45) begin errors++; $display("FAIL pre_lhit: got (%0d,%0d) want (5,45)", BallX, BallY); end
    do_step();
    checks++; if (BallX !== 8'd6) begin errors++; $display("FAIL lhit_edge_row: got %0d want 6", BallX); end
    do_step();
    checks++; if (BallX !== 8'd7) begin errors++; $display("FAIL lhit_dx_pos: got %0d want 7", BallX); end
  endtask

  task automatic test_miss_right;
    step_to(377);
    checks++; if (BallX !== 8'd159 || ScoreL !== 1'b0) begin errors++; $display("FAIL pre_missr: got x=%0d sl=%b want x=159 sl=0", BallX, ScoreL); end
    do_step();
    checks++; if (ScoreL !== 1'b1 || ScoreR !== 1'b0 || Active !== 1'b0) begin
      errors++; $display("FAIL missr_pulse: got sl=%b sr=%b act=%b want 1 0 0", ScoreL, ScoreR, Active); end
    @(negedge Clk);
    checks++; if (ScoreL !== 1'b0 || BallX !== 8'd80 || BallY !== 7'd60 || SpeedSel !== 4'd0) begin
      errors++; $display("FAIL missr_after: got sl=%b (%0d,%0d) spd=%0d want 0 (80,60) 0", ScoreL, BallX, BallY, SpeedSel); end
  endtask

  task automatic test_miss_left;
    PadLY = 7'd104;
    serve();
    step_to(75);
    checks++; if (BallX !== 8'd5 || BallY !== 7'd103) begin errors++; $display("FAIL leftserve: got (%0d,%0d) want (5,103)", BallX, BallY); end
    do_step();
    checks++; if (BallX !== 8'd4) begin errors++; $display("FAIL lnohit_above: got %0d want 4", BallX); end
    step_to(80);
    checks++; if (BallX !== 8'd0 || ScoreR !== 1'b0) begin errors++; $display("FAIL pre_missl: got x=%0d sr=%b want 0 0", BallX, ScoreR); end
    do_step();
    checks++; if (ScoreR !== 1'b1 || ScoreL !== 1'b0) begin errors++; $display("FAIL missl_pulse: got sr=%b sl=%b want 1 0", ScoreR, ScoreL); end
    checks++; if (BallX !== 8'd80 || BallY !== 7'd60) begin errors++; $display("FAIL missl_centre: got (%0d,%0d) want (80,60)", BallX, BallY); end
    @(negedge Clk);
    checks++; if (ScoreR !== 1'b0 || Active !== 1'b0) begin errors++; $display("FAIL missl_after: got sr=%b act=%b want 0 0", ScoreR, Active); end
  endtask

  task automatic test_speed_ramp_and_reset;
    serve();
    do_step();
    checks++; if (BallX !== 8'd81) begin errors++; $display("FAIL serve_toggle: got %0d want 81", BallX); end
    step_track(521);
    checks++; if (SpeedSel !== 4'd0) begin errors++; $display("FAIL ramp_3hits: got %0d want 0", SpeedSel); end
    step_track(522);
    checks++; if (SpeedSel !== 4'd1) begin errors++; $display("FAIL ramp_4hits: got %0d want 1", SpeedSel); end
    step_track(1117);
    checks++; if (SpeedSel !== 4'd1) begin errors++; $display("FAIL ramp_7hits: got %0d want 1", SpeedSel); end
    step_track(1118);
    checks++; if (SpeedSel !== 4'd2) begin errors++; $display("FAIL ramp_8hits: got %0d want 2", SpeedSel); end
    step_track(2310);
    checks++; if (SpeedSel !== 4'd3) begin errors++; $display("FAIL ramp_16hits: got %0d want 3", SpeedSel); end
    step_track(2906);
    checks++; if (SpeedSel !== 4'd3 || BallX !== 8'd6) begin errors++; $display("FAIL ramp_20hits: got spd=%0d x=%0d want 3 6", SpeedSel, BallX); end
    @(negedge Clk); #2 Rst = 1'b1; #1;
    checks++; if (BallX !== 8'd80 || BallY !== 7'd60 || SpeedSel !== 4'd0 || Active !== 1'b0) begin
      errors++; $display("FAIL async_rst: got (%0d,%0d) spd=%0d act=%b want (80,60) 0 0", BallX, BallY, SpeedSel, Active); end
    @(negedge Clk);
    checks++; if (ScoreL !== 1'b0 || ScoreR !== 1'b0) begin errors++; $display("FAIL async_rst_score: got %b%b want 00", ScoreL, ScoreR); end
    Rst = 1'b0;
  endtask

  task automatic test_speed_cleared_on_score;
    serve();
    do_step();
    checks++; if (BallX !== 8'd81) begin errors++; $display("FAIL rst_servedir: got %0d want 81", BallX); end
    step_track(522);
    checks++; if (SpeedSel !== 4'd1) begin errors++; $display("FAIL g4_4hits: got %0d want 1", SpeedSel); end
    PadLY = 7'd0; PadRY = 7'd0;
    step_to(670);
    checks++; if (BallX !== 8'd154 || BallY !== 7'd16) begin errors++; $display("FAIL g4_pre_rpad: got (%0d,%0d) want (154,16)", BallX, BallY); end
    do_step();
    checks++; if (BallX !== 8'd155) begin errors++; $display("FAIL rnohit_below: got %0d want 155", BallX); end
    step_to(676);
    checks++; if (ScoreL !== 1'b1 || SpeedSel !== 4'd0) begin errors++; $display("FAIL g4_miss: got sl=%b spd=%0d want 1 0", ScoreL, SpeedSel); end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_paddle_right();
    test_wall_bounce();
    test_paddle_left();
    test_miss_right();
    test_miss_left();
    test_speed_ramp_and_reset();
    test_speed_cleared_on_score();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
